// File: rtl/aes256_decrypt_core.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : aes256_decrypt_core (with package aes256_decrypt_pkg)      |
// | Description : Iterative AES-256 inverse cipher, one round per clock.     |
// |               Consumes the 15 round keys of an external key expander,    |
// |               accepts one ciphertext block per valid/ready handshake and |
// |               returns the plaintext through a second handshake.          |
// | Ports       :                                                            |
// |   clk                 in   single clock                                  |
// |   resetn              in   asynchronous active-low reset                 |
// |   round_keys_i        in   15 x 128 round keys (index 0 = first key)     |
// |   round_keys_valid_i  in   round keys complete and stable                |
// |   ciphertext_i        in   128-bit block, byte 0 = bits [127:120]        |
// |   ct_valid_i          in   ciphertext offered                            |
// |   ct_ready_o          out  core can accept a ciphertext (combinational)  |
// |   plaintext_o         out  decrypted block, same byte order             |
// |   pt_valid_o          out  plaintext_o valid                             |
// |   pt_ready_i          in   downstream accepts plaintext                  |
// |   busy_o              out  high while a block is in flight or held       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+

package aes256_decrypt_pkg;
    localparam int NUM_ROUND_KEYS = 15;
    typedef logic [NUM_ROUND_KEYS-1:0][127:0] round_keys_t;
endpackage

module aes256_decrypt_core
    import aes256_decrypt_pkg::*;
#(
    // Only 14 (AES-256) is supported; it sizes the round counter.
    parameter int NUM_ROUNDS = 14
) (
    input  logic         clk,
    input  logic         resetn,
    input  round_keys_t  round_keys_i,
    input  logic         round_keys_valid_i,
    input  logic [127:0] ciphertext_i,
    input  logic         ct_valid_i,
    output logic         ct_ready_o,
    output logic [127:0] plaintext_o,
    output logic         pt_valid_o,
    input  logic         pt_ready_i,
    output logic         busy_o
);

    localparam int               CNT_W         = $clog2(NUM_ROUNDS);
    localparam logic [CNT_W-1:0] C_FIRST_ROUND = CNT_W'(NUM_ROUNDS - 1);

    // Inverse S-box, entry 0 in the most significant byte.
    localparam logic [2047:0] C_INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        DONE  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // GF(2^8) helpers (polynomial 0x11B), built from xtime chains only
    // ------------------------------------------------------------------
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul_9(input logic [7:0] b);
        logic [7:0] x8;
        x8 = xtime(xtime(xtime(b)));
        return x8 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul_b(input logic [7:0] b);
        logic [7:0] x2;
        logic [7:0] x8;
        x2 = xtime(b);
        x8 = xtime(xtime(x2));
        return x8 ^ x2 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul_d(input logic [7:0] b);
        logic [7:0] x4;
        logic [7:0] x8;
        x4 = xtime(xtime(b));
        x8 = xtime(x4);
        return x8 ^ x4 ^ b;
    endfunction

    function automatic logic [7:0] gf_mul_e(input logic [7:0] b);
        logic [7:0] x2;
        logic [7:0] x4;
        logic [7:0] x8;
        x2 = xtime(b);
        x4 = xtime(x2);
        x8 = xtime(x4);
        return x8 ^ x4 ^ x2;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        return C_INV_SBOX[11'd2047 - {b, 3'b000} -: 8];
    endfunction

    // ------------------------------------------------------------------
    // Registers and wires
    // ------------------------------------------------------------------
    state_t             r_state;
    state_t             w_next_state;
    logic [CNT_W-1:0]   r_round;
    logic [127:0]       r_data;
    logic [127:0]       r_plaintext;
    logic               r_pt_valid;
    logic               r_busy;

    logic               w_accept;
    logic               w_round_en;
    logic               w_ct_ready;

    logic [127:0]       w_rk;
    logic [127:0]       w_isr;
    logic [127:0]       w_isb;
    logic [127:0]       w_ark;
    logic [127:0]       w_imc;
    logic [127:0]       w_round_out;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_round_en   = 1'b0;
        w_ct_ready   = 1'b0;
        case (r_state)
            IDLE: begin
                w_ct_ready = round_keys_valid_i;
                if (ct_valid_i && round_keys_valid_i) begin
                    w_accept     = 1'b1;
                    w_next_state = ROUND;
                end
            end
            ROUND: begin
                // Keys are not latched, so losing them mid-block aborts.
                if (!round_keys_valid_i) begin
                    w_next_state = IDLE;
                end else begin
                    w_round_en = 1'b1;
                    if (r_round == '0) begin
                        w_next_state = DONE;
                    end
                end
            end
            DONE: begin
                if (pt_ready_i) begin
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Gated by resetn so the port reads 0 while reset is held.
    assign ct_ready_o = w_ct_ready & resetn;

    // ------------------------------------------------------------------
    // Round datapath: InvShiftRows -> InvSubBytes -> AddRoundKey ->
    // InvMixColumns (skipped on the final round)
    // ------------------------------------------------------------------
    assign w_rk = round_keys_i[r_round];

    // Byte k of the block sits at row k%4, column k/4; row r rotates right by r.
    for (genvar c = 0; c < 4; c++) begin : g_isr_col
        for (genvar r = 0; r < 4; r++) begin : g_isr_row
            assign w_isr[127 - 8*(4*c + r) -: 8] =
                r_data[127 - 8*(4*((c - r + 4) % 4) + r) -: 8];
        end
    end

    for (genvar i = 0; i < 16; i++) begin : g_isb
        assign w_isb[8*i +: 8] = inv_sbox(w_isr[8*i +: 8]);
    end

    assign w_ark = w_isb ^ w_rk;

    for (genvar c = 0; c < 4; c++) begin : g_imc
        logic [7:0] w_a0;
        logic [7:0] w_a1;
        logic [7:0] w_a2;
        logic [7:0] w_a3;
        assign {w_a0, w_a1, w_a2, w_a3} = w_ark[127 - 32*c -: 32];
        assign w_imc[127 - 32*c -: 32] = {
            gf_mul_e(w_a0) ^ gf_mul_b(w_a1) ^ gf_mul_d(w_a2) ^ gf_mul_9(w_a3),
            gf_mul_9(w_a0) ^ gf_mul_e(w_a1) ^ gf_mul_b(w_a2) ^ gf_mul_d(w_a3),
            gf_mul_d(w_a0) ^ gf_mul_9(w_a1) ^ gf_mul_e(w_a2) ^ gf_mul_b(w_a3),
            gf_mul_b(w_a0) ^ gf_mul_d(w_a1) ^ gf_mul_9(w_a2) ^ gf_mul_e(w_a3)
        };
    end

    assign w_round_out = (r_round == '0) ? w_ark : w_imc;

    // ------------------------------------------------------------------
    // State, counter and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_data      <= '0;
            r_round     <= '0;
            r_plaintext <= '0;
            r_pt_valid  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_pt_valid <= (w_next_state == DONE);
            r_busy     <= (w_next_state != IDLE);
            if (w_accept) begin
                r_data  <= ciphertext_i ^ round_keys_i[NUM_ROUNDS];
                r_round <= C_FIRST_ROUND;
            end else if (w_round_en) begin
                r_data <= w_round_out;
                if (r_round == '0) begin
                    r_plaintext <= w_ark;
                end else begin
                    r_round <= r_round - CNT_W'(1);
                end
            end
        end
    end

    assign plaintext_o = r_plaintext;
    assign pt_valid_o  = r_pt_valid;
    assign busy_o      = r_busy;

endmodule

`default_nettype wire

// File: doc/aes256_decrypt_core.md
# aes256_decrypt_core

Iterative AES-256 inverse cipher (FIPS-197 InvCipher) that consumes the 15 round keys published by `key_expansion`. It sits downstream of the key generator, on the same clock. It accepts one 128-bit ciphertext block per valid/ready handshake and returns the plaintext through a second valid/ready handshake. One round is executed per clock.

## Interface
- `NUM_ROUNDS`, 14. AES-256 round count; sizes the round counter. Only 14 is supported.
- `clk`  in  1  single clock
- `resetn`  in  1  asynchronous, active-low reset
- `round_keys_i`  in  `round_keys_t` (15 x 128)  round keys; `round_keys_i[0]` is the first key word group, `round_keys_i[14]` the last
- `round_keys_valid_i`  in  1  round keys are complete and stable
- `ciphertext_i`  in  128  input block; byte 0 = bits [127:120], column-major state as FIPS-197
- `ct_valid_i`  in  1  ciphertext offered
- `ct_ready_o`  out  1  core can accept a ciphertext
- `plaintext_o`  out  128  decrypted block, same byte order
- `pt_valid_o`  out  1  `plaintext_o` valid
- `pt_ready_i`  in  1  downstream accepts plaintext
- `busy_o`  out  1  high in ROUND or DONE

## Operation
- **FSM states:** IDLE, ROUND, DONE.
- **IDLE:**
  - `ct_ready_o = round_keys_valid_i`.
  - On `ct_valid_i && ct_ready_o`, the state register loads `ciphertext_i ^ round_keys_i[14]`.
  - The round counter loads 13, and the FSM moves to ROUND.
- **ROUND, counter r:**
  - For r ≥ 1: the state becomes InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), round_keys_i[r])).
  - For r = 0: the state becomes AddRoundKey(InvSubBytes(InvShiftRows(state)), round_keys_i[0]), with no InvMixColumns. The result goes to `plaintext_o` and the FSM moves to DONE.
  - For r ≥ 1, r decrements by 1.
- **DONE:**
  - `pt_valid_o` = 1 and `plaintext_o` is held stable.
  - On `pt_ready_i`, the FSM goes to IDLE and `pt_valid_o` drops the next cycle.
- **Datapath rules:**
  - InvSubBytes uses a 256-entry inverse S-box, combinational.
  - InvMixColumns uses GF(2^8) with polynomial 0x11B and coefficients {0e,0b,0d,09}, implemented via xtime chains with no multipliers.
- **Key handling:** round keys are not latched. `round_keys_i` must stay stable from accept until DONE.
  - If `round_keys_valid_i` is low in any ROUND cycle, the operation aborts: the FSM returns to IDLE next cycle, no `pt_valid_o` is issued, and `plaintext_o` is unchanged.
  - `round_keys_valid_i` dropping in DONE has no effect; the completed result is still delivered.
- **Input flow control:** `ct_valid_i` while not IDLE is ignored, because `ct_ready_o` = 0. No input is queued.
- **Reset:** reset asserted mid-operation clears everything immediately, with no output.

## Timing
- **Reset values:** `ct_ready_o` 0, `pt_valid_o` 0, `plaintext_o` 0, `busy_o` 0, FSM IDLE, counter 0.
- **Latency:** accept at cycle T, rounds 13..0 execute in cycles T+1..T+14, and `pt_valid_o` rises at T+15.
- **Back-to-back operation:**
  - With `pt_ready_i` tied high, DONE lasts one cycle and `ct_ready_o` is high again at T+16.
  - Maximum throughput is one block per 16 cycles.
- **Registered outputs:** `ct_ready_o` is combinational from FSM state and `round_keys_valid_i`. All other outputs are registered.
- **Timing path:** the critical path per cycle is one InvShiftRows + InvSubBytes + XOR + InvMixColumns. There is no pipelining inside a round.

## Test plan
- **FIPS-197 C.3 vector:** load key 000102…1e1f and wait for `round_keys_valid_i`, then apply ct 8ea2b7ca516745bfeafc49904b496089. Required: pt 00112233445566778899aabbccddeeff with `pt_valid_o` exactly 15 cycles after accept.
- **SP800-38A ECB-AES256 vector:** key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4, ct f3eed1bdb5d2a03c064b5a7e3db181f8. Required: pt 6bc1bee22e409f96e93d7e117393172a. Then send two blocks back-to-back with `pt_ready_i` = 1; the second accept must occur 16 cycles after the first.
- **Output backpressure:** hold `pt_ready_i` = 0 for 10 cycles after `pt_valid_o`. Required: `plaintext_o` stable, `ct_ready_o` = 0, and `ct_valid_i` pulses not accepted. Release; `pt_valid_o` drops one cycle later.
- **Key not ready:** `round_keys_valid_i` = 0 with `ct_valid_i` = 1. Required: `ct_ready_o` = 0 and no accept. Next, drop `round_keys_valid_i` at round 7. Required: return to IDLE and no `pt_valid_o`. Finally, re-run the C.3 vector with the keys valid; the correct pt must be produced.
- **Mid-operation reset:** assert `resetn` = 0 asynchronously during round 5. Required: all outputs at their reset values immediately, and no spurious `pt_valid_o` after release. The next C.3 vector must decrypt correctly.
- **Randomised check:** 1000 random key/ct pairs against a reference model, with random `ct_valid_i`/`pt_ready_i` stalls. All outputs must match and no block may be dropped or duplicated.
